// File: rtl/board_io_pkg.sv
// Board-level I/O constants shared by the switch conditioning stage and top.
// Switch/LED widths and the debounce window for the 50 MHz system clock.
package board_io_pkg;

    localparam int SWITCH_COUNT           = 6;
    localparam int DEBOUNCE_10MS_AT_50MHZ = 500000;

endpackage : board_io_pkg

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, agreement counter and stable level,
// with registered single-cycle rise/fall strobes on each accepted change.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic s1_reg;
    (* ASYNC_REG = "TRUE" *) logic s2_reg;

    logic             stable_reg, stable_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             differs;
    logic             accept;

    // The counter only ever reaches CNT_LAST, where an accept clears it,
    // so it cannot wrap.
    always_comb begin
        stable_next = stable_reg;
        cnt_next    = cnt_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        differs     = (s2_reg != stable_reg);
        accept      = differs && (cnt_reg == CNT_LAST);

        if (!differs) begin
            cnt_next = '0;
        end else if (accept) begin
            stable_next = s2_reg;
            cnt_next    = '0;
            rise_next   = s2_reg;
            fall_next   = ~s2_reg;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            s1_reg     <= sw;
            s2_reg     <= s1_reg;
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    assign db   = stable_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the board slide switches; each bit is handled
// by an independent debounce_bit, with outputs indexed [WIDTH:1].
module switch_debouncer
    import board_io_pkg::*;
#(
    parameter int WIDTH           = SWITCH_COUNT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_50MHZ,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH:1]   Switch,
    output logic [WIDTH:1]   Switch_db,
    output logic [WIDTH:1]   Rise,
    output logic [WIDTH:1]   Fall
);

    genvar gi;
    generate
        for (gi = 1; gi <= WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .sw    (Switch[gi]),
                .db    (Switch_db[gi]),
                .rise  (Rise[gi]),
                .fall  (Fall[gi])
            );
        end
    endgenerate

endmodule : switch_debouncer

// File: doc/switch_debouncer.md
# switch_debouncer

Input-conditioning stage between the board slide switches and the LED/indicator logic in `top`. It synchronises each raw switch bit into the system clock domain and removes contact bounce. It presents a stable, debounced level per switch, plus single-cycle rise/fall strobes for downstream control logic such as CAN test-frame triggers. `top` consumes `Switch_db` in place of the raw `Switch` pins.

## Interface
Parameters:
- `WIDTH`, 6: number of switch bits; ports are indexed `[WIDTH:1]`.
- `DEBOUNCE_CYCLES`, 500000: consecutive clocks a synchronised input must differ from the stable value before it is accepted; legal range ≥ 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: counter width; derived, never overridden.

Ports:
- `clk`  in  1  system clock; one clock domain, all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Switch`  in  WIDTH  raw, asynchronous switch pins.
- `Switch_db`  out  WIDTH  debounced level, registered.
- `Rise`  out  WIDTH  one-cycle strobe when `Switch_db[i]` goes 0→1, registered.
- `Fall`  out  WIDTH  one-cycle strobe when `Switch_db[i]` goes 1→0, registered.

## Operation
- Each bit is fully independent; there is no cross-bit interaction.
- Per bit, state is:
  - `s1` and `s2`: two-flop synchroniser.
  - `stable`: drives `Switch_db[i]`.
  - `cnt[CNT_W-1:0]`: agreement counter.
- Reset (`rst_n` low, asynchronous): `s1`, `s2`, `stable`, `cnt`, `Switch_db`, `Rise` and `Fall` all go to 0 immediately, without waiting for a clock edge.
- Each clock with `s2 == stable`: `cnt` ← 0. Any glitch shorter than the window is discarded.
- Each clock with `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
- Each clock with `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`:
  - `stable` ← `s2` and `cnt` ← 0.
  - `Rise[i]` ← `s2`; `Fall[i]` ← `~s2`.
- In every other cycle, `Rise[i]` and `Fall[i]` are 0. `Rise[i]` and `Fall[i]` are never high together.
- The counter never wraps: it saturates at the compare point, and that point always causes an accept and clear.
- Reset mid-count: the partial count is lost. After release, a switch held at 1 is accepted as a fresh 0→1 change, with a `Rise` pulse.
- A bounce during the window that returns `s2` to `stable` for even one cycle restarts the window from 0.

## Timing
- `Switch` is captured into `s1` at edge E0, and is in `s2` after E1.
- `Switch_db` changes at edge E1+`DEBOUNCE_CYCLES`. Latency from the capture edge is therefore `DEBOUNCE_CYCLES`+1 clocks when the input is clean.
- `Rise`/`Fall` assert on the same edge that `Switch_db` changes and deassert on the next edge (exactly 1 cycle high).
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` clocks of constant `s2`. A pulse of `DEBOUNCE_CYCLES`-1 clocks produces no output change.
- With the default of 500000 at 50 MHz, the debounce window is 10 ms.
- No combinational path from any input to any output.

## Structure
- Sub-module `debounce_bit`: contains the synchroniser, counter and stable register for one bit. `switch_debouncer` instantiates `WIDTH` copies in a generate loop indexed 1..`WIDTH`.
- Shared package `board_io_pkg`:
  - `SWITCH_COUNT` = 6.
  - `DEBOUNCE_10MS_AT_50MHZ` = 500000.
  - These are also used by `top` for its `LED`/`Switch` widths.
- Synthesis constraint: mark the synchroniser flops as asynchronous registers (ASYNC_REG) so they are placed adjacent.

## Test plan
Every scenario runs with `DEBOUNCE_CYCLES`=4.
- Reset: assert `rst_n`=0 mid-cycle with `Switch`=6'b111111 → all outputs 0 immediately (asynchronously). Release → `Switch_db`=6'b111111 and `Rise`=6'b111111 for exactly one cycle at capture edge+5; `Fall`=0 throughout.
- Clean press/release on bit 3: set `Switch[3]`=1 at edge E0 → `Switch_db[3]`=1 and `Rise[3]`=1 at E0+5 only. Clear at E10 → `Switch_db[3]`=0 and `Fall[3]`=1 at E15. All other bits are unchanged.
- Glitch rejection on bit 1: a 3-clock-wide high pulse → `Switch_db[1]` stays 0 and no strobes. A 4-clock-wide high pulse → accepted, with `Rise[1]` pulsing once.
- Bounce restart on bit 6: high 2 clocks, low 1 clock, then high steady → `Switch_db[6]` rises 4 clocks after `s2` goes high the last time, with a single `Rise[6]` pulse.
- Simultaneous events: bit 2 rising while bit 5 falls on the same edge → `Rise[2]` and `Fall[5]` assert in the same cycle. Assert `rst_n`=0 mid-window on bit 4 → count lost and no strobe; after release the window restarts from 0.
